// File: rtl/tlc_pkg.sv
// Shared types, codes and lamp helpers for the junction phase scheduler.
package tlc_pkg;

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned NUM_PH  = 3;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } state_e;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    localparam logic [PHASE_W-1:0] PH_A = 2'd0;
    localparam logic [PHASE_W-1:0] PH_B = 2'd1;
    localparam logic [PHASE_W-1:0] PH_C = 2'd2;

    // One-hot mask for a phase id; an out-of-range id maps to no phase.
    function automatic logic [NUM_PH-1:0] ph_mask(logic [PHASE_W-1:0] ph);
        ph_mask = 3'b000;
        case (ph)
            PH_A:    ph_mask = 3'b001;
            PH_B:    ph_mask = 3'b010;
            PH_C:    ph_mask = 3'b100;
            default: ph_mask = 3'b000;
        endcase
    endfunction

    // Cyclic successor A->B->C->A.
    function automatic logic [PHASE_W-1:0] phase_inc(logic [PHASE_W-1:0] ph);
        phase_inc = PH_A;
        case (ph)
            PH_A:    phase_inc = PH_B;
            PH_B:    phase_inc = PH_C;
            default: phase_inc = PH_A;
        endcase
    endfunction

    // Packed lamp vector {c, b, a}: only the owning phase may show non-red.
    function automatic logic [3*2-1:0] lamp_vec(state_e st, logic [PHASE_W-1:0] cur);
        logic [1:0] code;
        code = LAMP_RED;
        if (st == GREEN) begin
            code = LAMP_GREEN;
        end else if (st == YELLOW) begin
            code = LAMP_YELLOW;
        end
        lamp_vec = 6'b000000;
        case (cur)
            PH_A:    lamp_vec[1:0] = code;
            PH_B:    lamp_vec[3:2] = code;
            PH_C:    lamp_vec[5:4] = code;
            default: lamp_vec      = 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational cyclic priority picker for the next green phase.
module tlc_rr_pick
    import tlc_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] cur_phase_i,
    input  logic       force_i,
    input  logic [1:0] target_i,
    output logic [1:0] next_phase_c
);

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] cand3;

    // Scan cur+1, cur+2, then cur itself; fall back to the rest phase A.
    always_comb begin
        cand1 = phase_inc(cur_phase_i);
        cand2 = phase_inc(cand1);
        cand3 = phase_inc(cand2);
        next_phase_c = PH_A;
        if (force_i) begin
            next_phase_c = target_i;
        end else if ((pending_i & ph_mask(cand1)) != 3'b000) begin
            next_phase_c = cand1;
        end else if ((pending_i & ph_mask(cand2)) != 3'b000) begin
            next_phase_c = cand2;
        end else if ((pending_i & ph_mask(cand3)) != 3'b000) begin
            next_phase_c = cand3;
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Tick-driven green/yellow/all-red phase scheduler with demand latching and preemption.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned G_MAIN_OFF  = 20,
    parameter int unsigned G_MAIN_PEAK = 40,
    parameter int unsigned G_SIDE      = 10,
    parameter int unsigned YELLOW_T    = 3,
    parameter int unsigned ALLRED_T    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       peak,
    input  logic [2:0] req,
    input  logic       preempt,
    input  logic [1:0] preempt_phase,
    output logic [1:0] lamp_a,
    output logic [1:0] lamp_b,
    output logic [1:0] lamp_c,
    output logic [1:0] cur_phase,
    output logic [1:0] state_o,
    output logic       phase_start
);

    state_e             state_q;
    logic [1:0]         cur_phase_q;
    logic [TIMER_W-1:0] timer_q;
    logic [2:0]         pending_q;
    logic [5:0]         lamps_q;
    logic               phase_start_q;

    logic               preempt_act;
    logic [2:0]         req_eff;
    logic [2:0]         pending_d;
    logic [TIMER_W-1:0] timer_dec;
    logic [TIMER_W-1:0] green_load;
    logic               green_exit;
    logic [1:0]         next_phase;

    tlc_rr_pick u_pick (
        .pending_i    (pending_d),
        .cur_phase_i  (cur_phase_q),
        .force_i      (preempt_act),
        .target_i     (preempt_phase),
        .next_phase_c (next_phase)
    );

    // Shared next-value terms: demand latch, saturating timer, green length, exit test.
    always_comb begin
        preempt_act = preempt && (preempt_phase != 2'd3);
        req_eff     = req & ~((state_q == GREEN) ? ph_mask(cur_phase_q) : 3'b000);
        pending_d   = pending_q | req_eff;
        timer_dec   = (tick && (timer_q != '0)) ? TIMER_W'(timer_q - 8'd1) : timer_q;
        if (next_phase == PH_A) begin
            green_load = peak ? TIMER_W'(G_MAIN_PEAK) : TIMER_W'(G_MAIN_OFF);
        end else begin
            green_load = TIMER_W'(G_SIDE);
        end
        green_exit = (timer_q == '0) && ((cur_phase_q != PH_A) || (pending_q[2:1] != 2'b00));
    end

    // Phase FSM with timer, demand latches and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ALLRED;
            cur_phase_q   <= PH_A;
            timer_q       <= TIMER_W'(ALLRED_T);
            pending_q     <= 3'b000;
            lamps_q       <= 6'b000000;
            phase_start_q <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            timer_q       <= timer_dec;
            phase_start_q <= 1'b0;
            case (state_q)
                GREEN: begin
                    if (preempt_act && (preempt_phase == cur_phase_q)) begin
                        timer_q <= timer_q;
                    end else if (preempt_act || green_exit) begin
                        state_q <= YELLOW;
                        timer_q <= TIMER_W'(YELLOW_T);
                        lamps_q <= lamp_vec(YELLOW, cur_phase_q);
                    end
                end
                YELLOW: begin
                    if (timer_q == '0) begin
                        state_q <= ALLRED;
                        timer_q <= TIMER_W'(ALLRED_T);
                        lamps_q <= 6'b000000;
                    end
                end
                ALLRED: begin
                    if (timer_q == '0) begin
                        state_q       <= GREEN;
                        cur_phase_q   <= next_phase;
                        timer_q       <= green_load;
                        pending_q     <= pending_d & ~ph_mask(next_phase);
                        lamps_q       <= lamp_vec(GREEN, next_phase);
                        phase_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ALLRED;
                    timer_q <= TIMER_W'(ALLRED_T);
                    lamps_q <= 6'b000000;
                end
            endcase
        end
    end

    assign lamp_a      = lamps_q[1:0];
    assign lamp_b      = lamps_q[3:2];
    assign lamp_c      = lamps_q[5:4];
    assign cur_phase   = cur_phase_q;
    assign state_o     = state_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Scoreboard bench for tlc_phase_scheduler: directed scenarios push expected phase events.
module tb_tlc_phase_scheduler;

    localparam logic [1:0] S_G = 2'd0;
    localparam logic [1:0] S_Y = 2'd1;
    localparam logic [1:0] S_R = 2'd2;
    localparam logic [1:0] P_A = 2'd0;
    localparam logic [1:0] P_B = 2'd1;
    localparam logic [1:0] P_C = 2'd2;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       peak;
    logic [2:0] req;
    logic       preempt;
    logic [1:0] preempt_phase;
    logic [1:0] lamp_a;
    logic [1:0] lamp_b;
    logic [1:0] lamp_c;
    logic [1:0] cur_phase;
    logic [1:0] state_o;
    logic       phase_start;

    typedef struct {
        logic [1:0] st;
        logic [1:0] ph;
        int         delta;
        logic       ps;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   tick_cnt = 0;
    int   cyc = 0;

    tlc_phase_scheduler #(
        .G_MAIN_OFF  (4),
        .G_MAIN_PEAK (6),
        .G_SIDE      (3),
        .YELLOW_T    (2),
        .ALLRED_T    (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .peak          (peak),
        .req           (req),
        .preempt       (preempt),
        .preempt_phase (preempt_phase),
        .lamp_a        (lamp_a),
        .lamp_b        (lamp_b),
        .lamp_c        (lamp_c),
        .cur_phase     (cur_phase),
        .state_o       (state_o),
        .phase_start   (phase_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tick every 4 clocks, counted when driven.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            tick = ((cyc % 4) == 0);
            if (tick) tick_cnt = tick_cnt + 1;
        end
    end

    function automatic logic [5:0] exp_lamps(logic [1:0] st, logic [1:0] ph);
        logic [5:0] v;
        v = 6'b000000;
        if (st == S_G) v = 6'(6'b000010 << (2 * ph));
        else if (st == S_Y) v = 6'(6'b000001 << (2 * ph));
        return v;
    endfunction

    task automatic push(input logic [1:0] st, input logic [1:0] ph, input int delta, input logic ps);
        exp_t e;
        e.st = st;
        e.ph = ph;
        e.delta = delta;
        e.ps = ps;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Monitor: every output change is one event, compared against the queue head.
    initial begin
        logic [9:0] prev;
        logic [9:0] now;
        logic [5:0] lv;
        int         base;
        exp_t       e;
        prev = '0;
        base = 0;
        forever begin
            @(posedge clk);
            #1;
            now = {state_o, cur_phase, lamp_c, lamp_b, lamp_a};
            lv  = {lamp_c, lamp_b, lamp_a};
            if (!reset) begin
                prev = now;
                base = tick_cnt;
            end else if (now != prev) begin
                total = total + 1;
                if (q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_event st=%0d ph=%0d lamps=%b at t=%0t",
                             state_o, cur_phase, lv, $time);
                end else begin
                    e = q.pop_front();
                    if (state_o != e.st || cur_phase != e.ph || lv != exp_lamps(e.st, e.ph) ||
                        phase_start != e.ps || (tick_cnt - base) != e.delta) begin
                        bad = bad + 1;
                        $display("FAIL event got st=%0d ph=%0d lamps=%b ps=%0d ticks=%0d want st=%0d ph=%0d lamps=%b ps=%0d ticks=%0d t=%0t",
                                 state_o, cur_phase, lv, phase_start, tick_cnt - base,
                                 e.st, e.ph, exp_lamps(e.st, e.ph), e.ps, e.delta, $time);
                    end
                end
                prev = now;
                base = tick_cnt;
            end else if (phase_start) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL stray_phase_start got=1 want=0 t=%0t", $time);
            end
        end
    end

    // Assert reset now, check safe-red values, release on a negedge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", int'(state_o), int'(S_R));
        chk("rst_phase", int'(cur_phase), int'(P_A));
        chk("rst_lamps", int'({lamp_c, lamp_b, lamp_a}), 0);
        chk("rst_phase_start", int'(phase_start), 0);
        repeat (3) @(negedge clk);
        push(S_G, P_A, 1, 1'b1);
        reset = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] st, input logic [1:0] ph);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (state_o == st && cur_phase == ph) hit = 1'b1;
        end
        if (!hit) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL wait_timeout got st=%0d ph=%0d want st=%0d ph=%0d", state_o, cur_phase, st, ph);
        end
    endtask

    task automatic wait_ticks(input int n);
        int tgt;
        tgt = tick_cnt + n;
        for (int i = 0; i < 1000 && tick_cnt < tgt; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_req(input logic [2:0] v);
        req = v;
        @(posedge clk);
        #1;
        req = 3'b000;
    endtask

    task automatic expect_quiet(input string name, input int n);
        wait_ticks(n);
        chk(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        peak = 1'b0;
        req = 3'b000;
        preempt = 1'b0;
        preempt_phase = 2'd0;
        repeat (2) @(negedge clk);

        // Reset, no demand: A green after the first tick, then rests; preempt on A is a no-op.
        do_reset();
        wait_state(S_G, P_A);
        preempt = 1'b1;
        preempt_phase = P_A;
        expect_quiet("s1_rest", 6);
        preempt = 1'b0;

        // Single B request; preempt_phase=3 must be ignored throughout.
        do_reset();
        preempt = 1'b1;
        preempt_phase = 2'd3;
        wait_state(S_G, P_A);
        push(S_Y, P_A, 4, 1'b0);
        push(S_R, P_A, 2, 1'b0);
        push(S_G, P_B, 1, 1'b1);
        push(S_Y, P_B, 3, 1'b0);
        push(S_R, P_B, 2, 1'b0);
        push(S_G, P_A, 1, 1'b1);
        pulse_req(3'b010);
        wait_state(S_G, P_B);
        wait_state(S_G, P_A);
        expect_quiet("s2_rest", 6);
        preempt = 1'b0;
        preempt_phase = 2'd0;

        // B and C together: B, then C, then back to A once each.
        do_reset();
        wait_state(S_G, P_A);
        push(S_Y, P_A, 4, 1'b0);
        push(S_R, P_A, 2, 1'b0);
        push(S_G, P_B, 1, 1'b1);
        push(S_Y, P_B, 3, 1'b0);
        push(S_R, P_B, 2, 1'b0);
        push(S_G, P_C, 1, 1'b1);
        push(S_Y, P_C, 3, 1'b0);
        push(S_R, P_C, 2, 1'b0);
        push(S_G, P_A, 1, 1'b1);
        pulse_req(3'b110);
        wait_state(S_G, P_C);
        wait_state(S_G, P_A);
        expect_quiet("s3_rest", 6);

        // Peak sampled at A entry only: 6-tick green despite toggling low.
        peak = 1'b1;
        do_reset();
        wait_state(S_G, P_A);
        peak = 1'b0;
        push(S_Y, P_A, 6, 1'b0);
        push(S_R, P_A, 2, 1'b0);
        push(S_G, P_B, 1, 1'b1);
        push(S_Y, P_B, 3, 1'b0);
        push(S_R, P_B, 2, 1'b0);
        push(S_G, P_A, 1, 1'b1);
        pulse_req(3'b010);
        wait_state(S_G, P_B);
        wait_state(S_G, P_A);
        expect_quiet("s4_rest", 6);

        // Preempt to C at A timer 3: immediate yellow, C held, then 3 more ticks.
        do_reset();
        wait_state(S_G, P_A);
        wait_ticks(1);
        push(S_Y, P_A, 1, 1'b0);
        push(S_R, P_A, 2, 1'b0);
        push(S_G, P_C, 1, 1'b1);
        preempt = 1'b1;
        preempt_phase = P_C;
        wait_state(S_G, P_C);
        wait_ticks(5);
        chk("s5_hold", q.size(), 0);
        push(S_Y, P_C, 8, 1'b0);
        push(S_R, P_C, 2, 1'b0);
        push(S_G, P_A, 1, 1'b1);
        preempt = 1'b0;
        preempt_phase = 2'd0;
        wait_state(S_G, P_A);
        expect_quiet("s5_rest", 6);

        // Reset mid B-yellow with C pending: safe-red at once, pending discarded.
        do_reset();
        wait_state(S_G, P_A);
        push(S_Y, P_A, 4, 1'b0);
        push(S_R, P_A, 2, 1'b0);
        push(S_G, P_B, 1, 1'b1);
        push(S_Y, P_B, 3, 1'b0);
        pulse_req(3'b010);
        wait_state(S_Y, P_B);
        pulse_req(3'b100);
        chk("s6_before_reset", q.size(), 0);
        #2;
        do_reset();
        wait_state(S_G, P_A);
        expect_quiet("s6_pending_cleared", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
